par_serializer: RTL and testbench
=================================

# par_serializer

Parametrised N:1 serializer for CH parallel lanes, built in fabric logic and clocked from a single bit-rate clock. It accepts one CH×DATA_W word per DATA_W clocks over a valid/ready handshake and shifts every lane out LSB-first with a common word boundary. When no word is available at a boundary, it inserts an idle word and counts the underrun. It sits between the encoder/packetiser and the output pads, in place of the fixed 10:1 primitive-based serializer, wherever lane count or word width differ.

## Interface
- DATA_W, 10: bits per lane word; minimum 2.
- CH, 3: number of lanes.
- IDLE_WORD, 10'h354: DATA_W-bit word sent on every lane on underrun.
- clk_i  in  1  bit-rate clock; single clock domain.
- a_rst_i  in  1  reset; asynchronous assertion, active-high.
- p_data_i  in  CH*DATA_W  parallel word; lane c occupies [c*DATA_W +: DATA_W].
- p_valid_i  in  1  p_data_i valid.
- p_ready_o  out  1  block can accept a word this cycle.
- s_data_o  out  CH  serial bit per lane, registered.
- word_start_o  out  1  high while s_data_o carries bit 0 of a word.
- underrun_o  out  1  one-cycle pulse per idle word inserted.
- underrun_cnt_o  out  16  saturating underrun count.
- bitslip_i  in  1  present only with PAR_SER_BITSLIP_EN; see Configuration.

## Operation
- State:
  - bit_cnt: 0..DATA_W-1.
  - Per-lane shift register sh[c].
  - One-entry holding register hold with flag hold_v.
- A load cycle is any cycle with bit_cnt == DATA_W-1.
- p_ready_o = !hold_v. It is driven directly from a flop, with no combinational path from p_valid_i.
- Transfer = p_valid_i && p_ready_o.
- Every cycle:
  - s_data_o[c] <= sh[c][0].
  - word_start_o <= (bit_cnt == 0).
  - sh[c] shifts right by one.
  - bit_cnt increments.
- On a load cycle, bit_cnt wraps to 0 and sh is loaded from the first available source, in priority order:
  1. If hold_v: load hold and clear hold_v. A transfer in this cycle is impossible because ready is low.
  2. Else, if transfer: bypass, loading p_data_i directly into sh. hold_v stays 0.
  3. Else: underrun. Load IDLE_WORD into every lane, set underrun_o for the next cycle, and increment underrun_cnt_o, saturating at 16'hFFFF.
- On a non-load cycle, a transfer writes hold and sets hold_v.
- Lanes are never skewed; all lanes load on the same edge.
- Reset mid-word: the partial word and the held word are discarded, with no flush.

## Timing
- Reset values:
  - s_data_o = 0, word_start_o = 0, underrun_o = 0, underrun_cnt_o = 0, p_ready_o = 1.
  - sh = 0, hold_v = 0.
  - bit_cnt = DATA_W-1, so the first cycle after reset release is a load cycle.
- Bypass latency: a word transferred in a load cycle at edge E drives bit 0 on s_data_o from edge E+2, with word_start_o high for that cycle.
- Held words go out at the next load cycle. Bit k of lane c appears on s_data_o[c] k cycles after bit 0.
- Throughput: one word per DATA_W cycles. p_ready_o is low from the edge after a non-load transfer until the edge after the next load cycle.
- word_start_o pulses exactly every DATA_W cycles, including during underrun.
- underrun_o is aligned with word_start_o for the idle word.

## Configuration
- PAR_SER_BITSLIP_EN defined:
  - Adds input bitslip_i and a slip counter slip (0..DATA_W-1, reset 0).
  - A cycle with bitslip_i=1 increments slip modulo DATA_W, so DATA_W-1 wraps to 0.
  - Every word loaded into sh, including IDLE_WORD, is first rotated right by slip, so bit[slip] is sent first. The rotation uses the slip value registered before the load edge.
  - bitslip_i asserted on a load cycle affects the following word only.
- PAR_SER_BITSLIP_EN not defined:
  - No bitslip_i port and no rotation; words are sent unmodified, LSB first.

## Test plan
- Reset, then hold p_valid_i=0 for 30 cycles:
  - s_data_o carries 10'h354 LSB-first on all 3 lanes.
  - word_start_o pulses at cycles 2, 12 and 22 after release.
  - underrun_cnt_o = 3.
- Stream 10'h3FF, 10'h000 and 10'h2AA on lane 0 back to back, with valid held high:
  - Serial output is ten 1s, ten 0s, then 0101010101.
  - p_ready_o toggles once per word; no underrun after the first word.
- Present a word exactly on a load cycle with hold empty:
  - Bypass occurs; bit 0 appears two edges later with word_start_o=1.
- Stall the source for one word period mid-stream:
  - Exactly one idle word is inserted, underrun_o pulses once, and the stream then resumes aligned.
- Assert a_rst_i at bit 4 of a word with hold full:
  - All outputs reach reset values immediately.
  - After release, the first word out is IDLE_WORD and the held word is lost.
- With PAR_SER_BITSLIP_EN, pulse bitslip_i 3 times and send 10'h001:
  - The lone 1 appears at serial position 7 of the word.
  - 10 further pulses leave alignment unchanged.

Source files
------------

// File: rtl/par_serializer.sv
// CH-lane DATA_W:1 serializer with a one-word holding register, idle-word underrun fill and a common word boundary.
// Optional define PAR_SER_BITSLIP_EN adds bitslip_i and per-word rotate-right by the registered slip count.
module par_serializer #(
   parameter int                DATA_W    = 10,
   parameter int                CH        = 3,
   parameter logic [DATA_W-1:0] IDLE_WORD = 10'h354
) (
   input  logic                 clk_i,
   input  logic                 a_rst_i,
   input  logic [CH*DATA_W-1:0] p_data_i,
   input  logic                 p_valid_i,
   output logic                 p_ready_o,
`ifdef PAR_SER_BITSLIP_EN
   input  logic                 bitslip_i,
`endif
   output logic [CH-1:0]        s_data_o,
   output logic                 word_start_o,
   output logic                 underrun_o,
   output logic [15:0]          underrun_cnt_o
);

   localparam int               CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

   logic [CNT_W-1:0]       bit_cnt_r;
   logic [CH*DATA_W-1:0]   sh_r;
   logic [CH*DATA_W-1:0]   hold_r;
   logic                   hold_v_r;
   logic                   idle_pend_r;
   logic                   load_s;
   logic                   xfer_s;
   logic                   underrun_s;
   logic [CH*DATA_W-1:0]   src_s;
   logic [CH*DATA_W-1:0]   load_word_s;

   assign load_s = (bit_cnt_r == LAST);
   assign xfer_s = p_valid_i && p_ready_o;

   // Select the word for the next boundary: held word, then bypass, then idle fill
   always_comb begin
      src_s      = {CH{IDLE_WORD}};
      underrun_s = 1'b0;
      if (hold_v_r) begin
         src_s = hold_r;
      end else if (xfer_s) begin
         src_s = p_data_i;
      end else begin
         src_s      = {CH{IDLE_WORD}};
         underrun_s = 1'b1;
      end
   end

`ifdef PAR_SER_BITSLIP_EN
   logic [CNT_W-1:0] slip_r;

   // Rotate every lane right by s so that bit[s] leaves first
   function automatic logic [CH*DATA_W-1:0] rotate_lanes(input logic [CH*DATA_W-1:0] w,
                                                          input logic [CNT_W-1:0]     s);
      logic [CH*DATA_W-1:0] r;
      int                   idx;
      r = w;
      for (int c = 0; c < CH; c++) begin
         for (int i = 0; i < DATA_W; i++) begin
            idx = i + int'(s);
            if (idx >= DATA_W) begin
               idx = idx - DATA_W;
            end else begin
               idx = idx;
            end
            r[c*DATA_W+i] = w[c*DATA_W+idx];
         end
      end
      return r;
   endfunction

   // Slip counter, modulo DATA_W
   always_ff @(posedge clk_i or posedge a_rst_i) begin
      if (a_rst_i) begin
         slip_r <= {CNT_W{1'b0}};
      end else if (bitslip_i) begin
         slip_r <= (slip_r == LAST) ? {CNT_W{1'b0}} : slip_r + CNT_W'(1);
      end
   end

   assign load_word_s = rotate_lanes(src_s, slip_r);
`else
   assign load_word_s = src_s;
`endif

   // Bit counter, shift lanes, holding register, handshake and underrun reporting
   always_ff @(posedge clk_i or posedge a_rst_i) begin
      if (a_rst_i) begin
         bit_cnt_r      <= LAST;
         sh_r           <= {(CH*DATA_W){1'b0}};
         hold_r         <= {(CH*DATA_W){1'b0}};
         hold_v_r       <= 1'b0;
         idle_pend_r    <= 1'b0;
         p_ready_o      <= 1'b1;
         s_data_o       <= {CH{1'b0}};
         word_start_o   <= 1'b0;
         underrun_o     <= 1'b0;
         underrun_cnt_o <= 16'h0000;
      end else begin
         for (int c = 0; c < CH; c++) begin
            s_data_o[c] <= sh_r[c*DATA_W];
         end
         word_start_o <= (bit_cnt_r == {CNT_W{1'b0}});
         // The idle pulse is reported on the edge that puts the idle word's bit 0 out
         underrun_o   <= idle_pend_r;
         if (idle_pend_r && (underrun_cnt_o != 16'hFFFF)) begin
            underrun_cnt_o <= underrun_cnt_o + 16'd1;
         end
         if (load_s) begin
            bit_cnt_r   <= {CNT_W{1'b0}};
            sh_r        <= load_word_s;
            hold_v_r    <= 1'b0;
            p_ready_o   <= 1'b1;
            idle_pend_r <= underrun_s;
         end else begin
            bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
            idle_pend_r <= 1'b0;
            for (int c = 0; c < CH; c++) begin
               sh_r[c*DATA_W +: DATA_W] <= {1'b0, sh_r[c*DATA_W+1 +: DATA_W-1]};
            end
            if (xfer_s) begin
               hold_r    <= p_data_i;
               hold_v_r  <= 1'b1;
               p_ready_o <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_par_serializer.sv
// Randomized self-checking bench for par_serializer against a word-level schedule model.
module tb_par_serializer;
   localparam int            DW   = 10;
   localparam int            CH   = 3;
   localparam logic [DW-1:0] IDLE = 10'h354;

   logic            clk = 1'b0;
   logic            a_rst = 1'b1;
   logic [CH*DW-1:0] p_data = '0;
   logic            p_valid = 1'b0;
   logic            bitslip = 1'b0;
   logic            p_ready;
   logic [CH-1:0]   s_data;
   logic            ws;
   logic            ur;
   logic [15:0]     ucnt;

   always #5 clk = ~clk;

   par_serializer #(.DATA_W(DW), .CH(CH), .IDLE_WORD(IDLE)) dut (
      .clk_i(clk),
      .a_rst_i(a_rst),
      .p_data_i(p_data),
      .p_valid_i(p_valid),
      .p_ready_o(p_ready),
`ifdef PAR_SER_BITSLIP_EN
      .bitslip_i(bitslip),
`endif
      .s_data_o(s_data),
      .word_start_o(ws),
      .underrun_o(ur),
      .underrun_cnt_o(ucnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Word-level model: m_t counts edges since reset release; loads happen at t = 1, 1+DW, ...
   int               m_t = 0;
   int               m_slip = 0;
   int               e_cnt = 0;
   bit               m_pend_v = 0, m_ld_idle = 0, m_xfer = 0;
   bit               e_ws = 0, e_ur = 0, e_ready = 1;
   logic [CH*DW-1:0] m_pend = '0, m_ld = '0, m_out = '0;
   logic [CH-1:0]    e_s = '0;

   logic [CH-1:0] cap_s [0:127];
   bit            cap_ws[0:127];
   bit            cap_ur[0:127];

   function automatic logic [CH*DW-1:0] rot_lanes(input logic [CH*DW-1:0] w, input int s);
      logic [CH*DW-1:0] r;
      for (int c = 0; c < CH; c++)
         for (int i = 0; i < DW; i++)
            r[c*DW+i] = w[c*DW + (i + s) % DW];
      return r;
   endfunction

   always @(posedge clk) begin
      if (a_rst) begin
         m_t = 0; m_pend_v = 0; m_ld = '0; m_out = '0; m_ld_idle = 0; m_xfer = 0;
         m_slip = 0; e_s = '0; e_ws = 0; e_ur = 0; e_ready = 1; e_cnt = 0;
      end else begin
         m_t++;
         m_xfer = p_valid && e_ready;
         if (m_t >= 2 && (m_t - 2) % DW == 0) begin
            m_out = m_ld;
            e_ws  = 1;
            e_ur  = m_ld_idle;
            if (m_ld_idle && e_cnt < 65535) e_cnt++;
         end else begin
            e_ws = 0;
            e_ur = 0;
         end
         if (m_t >= 2)
            for (int c = 0; c < CH; c++) e_s[c] = m_out[c*DW + (m_t - 2) % DW];
         if ((m_t - 1) % DW == 0) begin
            if (m_pend_v) begin
               m_ld = rot_lanes(m_pend, m_slip); m_pend_v = 0; m_ld_idle = 0;
            end else if (m_xfer) begin
               m_ld = rot_lanes(p_data, m_slip); m_ld_idle = 0;
            end else begin
               m_ld = rot_lanes({CH{IDLE}}, m_slip); m_ld_idle = 1;
            end
         end else if (m_xfer) begin
            m_pend = p_data; m_pend_v = 1;
         end
         e_ready = !m_pend_v;
         m_slip  = (m_slip + int'(bitslip)) % DW;
      end
   end

   // Single compare process, away from the active edge
   always @(negedge clk) begin
      if (!a_rst && m_t > 0) begin
         chk("s_data", s_data, e_s);
         chk("word_start", ws, e_ws);
         chk("underrun", ur, e_ur);
         chk("underrun_cnt", ucnt, e_cnt);
         chk("p_ready", p_ready, e_ready);
         if (m_t < 128) begin
            cap_s[m_t]  = s_data;
            cap_ws[m_t] = ws;
            cap_ur[m_t] = ur;
         end
      end
   end

   task automatic release_rst();
      @(negedge clk); #2 a_rst = 1'b0;
   endtask

   task automatic wait_t(input int n);
      int guard = 0;
      while (m_t < n && guard < 400) begin
         @(posedge clk); #1; guard++;
      end
      if (m_t != n) begin
         n_checks++;
         $display("FAIL wait_t: reached t=%0d required t=%0d", m_t, n);
      end
   endtask

   task automatic send_word(input logic [CH*DW-1:0] d);
      int guard = 0;
      p_valid = 1'b1;
      p_data  = d;
      do begin
         @(posedge clk); #1; guard++;
      end while (!m_xfer && guard < 3*DW);
      if (!m_xfer) begin
         n_checks++;
         $display("FAIL send_timeout: word %0h not accepted within %0d cycles", d, 3*DW);
      end
   endtask

   function automatic logic [CH*DW-1:0] rnd_word();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[CH*DW-1:0];
   endfunction

   function automatic logic [CH*DW-1:0] lane0(input logic [DW-1:0] w);
      logic [CH*DW-1:0] r;
      r = rnd_word();
      r[DW-1:0] = w;
      return r;
   endfunction

   logic [30:0]      ws_act, ws_exp;
   logic [CH*DW-1:0] lanes_act, dbyp;
   logic [29:0]      l0_act, l0_exp;
   logic [DW-1:0]    w_act;
   logic [CH-1:0]    b_exp;
   int               cnt_ur;

   initial begin
      // Idle after reset: idle words, word_start at 2/12/22, three underruns
      repeat (2) @(posedge clk);
      release_rst();
      wait_t(30);
      @(negedge clk); #1;
      ws_exp = '0; ws_exp[2] = 1'b1; ws_exp[12] = 1'b1; ws_exp[22] = 1'b1;
      ws_act = '0;
      for (int i = 1; i <= 30; i++) ws_act[i] = cap_ws[i];
      chk("ws_period", ws_act, ws_exp);
      chk("idle_cnt", ucnt, 64'd3);
      for (int i = 0; i < DW; i++)
         for (int c = 0; c < CH; c++) lanes_act[c*DW+i] = cap_s[2+i][c];
      chk("idle_word", lanes_act, {CH{IDLE}});

      // Back-to-back stream, then a stall long enough to force one idle word
      a_rst = 1'b1;
      repeat (2) @(posedge clk);
      release_rst();
      send_word(lane0(10'h3FF));
      send_word(lane0(10'h000));
      send_word(lane0(10'h2AA));
      send_word(rnd_word());
      p_valid = 1'b0;
      wait_t(41);
      send_word(rnd_word());
      send_word(rnd_word());
      send_word(rnd_word());
      p_valid = 1'b0;
      wait_t(71);
      @(negedge clk); #1;
      for (int i = 0; i < 30; i++) l0_act[i] = cap_s[2+i][0];
      l0_exp = {10'h2AA, 10'h000, 10'h3FF};
      chk("stream_lane0", l0_act, l0_exp);
      cnt_ur = 0;
      for (int i = 2; i <= 31; i++) cnt_ur += int'(cap_ur[i]);
      chk("no_early_underrun", cnt_ur, 64'd0);
      cnt_ur = 0;
      for (int i = 2; i <= 71; i++) cnt_ur += int'(cap_ur[i]);
      chk("stall_pulses", cnt_ur, 64'd1);
      chk("stall_cnt", ucnt, 64'd1);
      chk("stall_resume_ws", cap_ws[52], 64'd1);

      // Bypass: present on the load cycle with hold empty
      wait_t(80);
      dbyp    = rnd_word();
      p_valid = 1'b1;
      p_data  = dbyp;
      @(posedge clk); #1;
      p_valid = 1'b0;
      @(posedge clk); #1;
      for (int c = 0; c < CH; c++) b_exp[c] = dbyp[c*DW];
      chk("bypass_bit0", s_data, b_exp);
      chk("bypass_ws", ws, 64'd1);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         p_valid = ($urandom_range(0, 3) != 0);
         p_data  = rnd_word();
`ifdef PAR_SER_BITSLIP_EN
         bitslip = ($urandom_range(0, 7) == 0);
`endif
         @(posedge clk); #1;
      end
      p_valid = 1'b0;
      bitslip = 1'b0;

      // Reset at bit 4 with the holding register full
      a_rst = 1'b1;
      repeat (2) @(posedge clk);
      release_rst();
      for (int k = 0; k < 200; k++) begin
         p_valid = 1'b1;
         p_data  = rnd_word();
         @(posedge clk); #1;
         if (m_pend_v && m_t >= 2 && (m_t - 2) % DW == 4) break;
      end
      a_rst   = 1'b1;
      p_valid = 1'b0;
      #1;
      chk("rst_s_data", s_data, 64'd0);
      chk("rst_ws", ws, 64'd0);
      chk("rst_ur", ur, 64'd0);
      chk("rst_cnt", ucnt, 64'd0);
      chk("rst_ready", p_ready, 64'd1);
      repeat (2) @(posedge clk);
      release_rst();
      wait_t(12);
      @(negedge clk); #1;
      for (int i = 0; i < DW; i++)
         for (int c = 0; c < CH; c++) lanes_act[c*DW+i] = cap_s[2+i][c];
      chk("post_rst_idle", lanes_act, {CH{IDLE}});
      chk("post_rst_ur", cap_ur[2], 64'd1);

`ifdef PAR_SER_BITSLIP_EN
      // Three slips move bit 0 to serial position 7; ten more leave it there
      a_rst = 1'b1;
      repeat (2) @(posedge clk);
      release_rst();
      @(posedge clk); #1;
      bitslip = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      bitslip = 1'b0;
      wait_t(10);
      p_valid = 1'b1;
      p_data  = {CH{10'h001}};
      @(posedge clk); #1;
      p_valid = 1'b0;
      bitslip = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      bitslip = 1'b0;
      wait_t(30);
      for (int i = 0; i < DW; i++) w_act[i] = cap_s[12+i][0];
      chk("slip3_pos", w_act, 64'h080);
      p_valid = 1'b1;
      p_data  = {CH{10'h001}};
      @(posedge clk); #1;
      p_valid = 1'b0;
      wait_t(41);
      @(negedge clk); #1;
      for (int i = 0; i < DW; i++) w_act[i] = cap_s[32+i][0];
      chk("slip13_pos", w_act, 64'h080);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
